pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/proc_pkg.sv | 24 ++
 rtl/pc_reg.sv | 37 +++
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   - state_t     : sequencer FSM states
//   - PC_W_DEF    : default program-counter width
//   - HALT_OP_DEF : default opcode (instr[31:26]) that halts the sequencer
//   - sat_inc16   : saturating 16-bit increment used by the retire counter
package proc_pkg;

    localparam int         PC_W_DEF    = 6;
    localparam logic [5:0] HALT_OP_DEF = 6'h3F;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register.
// Ports:
//   clk   : clock
//   i_clr : synchronous clear to 0 (highest priority)
//   i_ld  : load i_d
//   i_inc : increment by one, wrapping from all-ones to 0
//   i_d   : load value
//   o_q   : current program counter
module pc_reg
    import proc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            i_clr,
    input  logic            i_ld,
    input  logic            i_inc,
    input  logic [PC_W-1:0] i_d,
    output logic [PC_W-1:0] o_q
);

    logic [PC_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end else if (i_inc) begin
            // Natural modulo-2^PC_W wrap; no overflow flag is wanted.
            r_q <= r_q + PC_W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with an absorbing HALT state entered when the decoded opcode is HALT_OP.
// Ports:
//   clk, clkreset              : clock and synchronous active-high reset
//   run                        : permission to start a new instruction
//   imem_req/imem_addr         : fetch request and address (address == pc)
//   imem_ack/imem_data         : fetch completion and instruction word
//   instr                      : latched current instruction
//   dec_valid                  : high for the single DECODE cycle
//   ex_en/ex_done              : execute enable and datapath completion
//   branch_taken/branch_target : redirect, sampled together with ex_done
//   rf_we                      : high for the single WRITEBACK cycle
//   pc, retired, halted        : program counter, retire count, halt flag
// Every output is either a register or a decode of the state register.
module pc_sequencer
    import proc_pkg::*;
#(
    parameter int         PC_W    = PC_W_DEF,
    parameter logic [5:0] HALT_OP = HALT_OP_DEF
) (
    input  logic            clk,
    input  logic            clkreset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instr,
    output logic            dec_valid,
    output logic            ex_en,
    input  logic            ex_done,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            rf_we,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired,
    output logic            halted
);

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_instr;
    logic [15:0]     r_retired;
    logic            r_br_taken;
    logic [PC_W-1:0] r_br_target;
    logic [PC_W-1:0] w_pc;
    logic            w_pc_ld;
    logic            w_pc_inc;

    // The redirect decision is captured at ex_done and applied at the
    // WRITEBACK edge, so pc only ever changes once per instruction.
    assign w_pc_ld  = (r_state == WRITEBACK) &&  r_br_taken;
    assign w_pc_inc = (r_state == WRITEBACK) && !r_br_taken;

    pc_reg #(
        .PC_W (PC_W)
    ) u_pc_reg (
        .clk   (clk),
        .i_clr (clkreset),
        .i_ld  (w_pc_ld),
        .i_inc (w_pc_inc),
        .i_d   (r_br_target),
        .o_q   (w_pc)
    );

    always_ff @(posedge clk) begin
        if (clkreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (clkreset) begin
            r_instr    <= '0;
            r_retired  <= '0;
            r_br_taken <= 1'b0;
        end else begin
            if (r_state == FETCH && imem_ack) begin
                r_instr <= imem_data;
            end
            if (r_state == EXECUTE && ex_done) begin
                r_br_taken <= branch_taken;
            end
            if (r_state == WRITEBACK) begin
                r_retired <= sat_inc16(r_retired);
            end
        end
    end

    // Target is only consumed when r_br_taken is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == EXECUTE && ex_done) begin
            r_br_target <= branch_target;
        end
    end

    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        dec_valid = 1'b0;
        ex_en     = 1'b0;
        rf_we     = 1'b0;
        halted    = 1'b0;
        case (r_state)
            IDLE: begin
                if (run) w_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_next = DECODE;
            end
            DECODE: begin
                dec_valid = 1'b1;
                w_next    = (r_instr[31:26] == HALT_OP) ? HALT : EXECUTE;
            end
            EXECUTE: begin
                ex_en = 1'b1;
                if (ex_done) w_next = WRITEBACK;
            end
            WRITEBACK: begin
                rf_we  = 1'b1;
                w_next = run ? FETCH : IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign imem_addr = w_pc;
    assign pc        = w_pc;
    assign instr     = r_instr;
    assign retired   = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. The bench plays instruction memory
// and datapath, and tracks the architectural result of each instruction
// (next pc, retire count, handshake latency) at the transaction level.
module tb_pc_sequencer;

    localparam int         PC_W    = 6;
    localparam logic [5:0] HALT_OP = 6'h3F;

    logic            clk;
    logic            clkreset;
    logic            run;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_data;
    logic [31:0]     instr;
    logic            dec_valid;
    logic            ex_en;
    logic            ex_done;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            rf_we;
    logic [PC_W-1:0] pc;
    logic [15:0]     retired;
    logic            halted;

    int n_chk  = 0;
    int n_pass = 0;

    logic [PC_W-1:0] m_pc;
    logic [15:0]     m_ret;

    pc_sequencer #(
        .PC_W    (PC_W),
        .HALT_OP (HALT_OP)
    ) dut (
        .clk           (clk),
        .clkreset      (clkreset),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr         (instr),
        .dec_valid     (dec_valid),
        .ex_en         (ex_en),
        .ex_done       (ex_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .rf_we         (rf_we),
        .pc            (pc),
        .retired       (retired),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] v;
        v = $urandom;
        if (v[31:26] == HALT_OP) v[26] = ~v[26];
        return v;
    endfunction

    // Entered at a falling edge with the DUT in FETCH. Returns at a falling
    // edge with the DUT in FETCH (keep_run=1), IDLE (keep_run=0) or HALT.
    task automatic do_instr(input int ad, input int dd, input bit br,
                            input logic [PC_W-1:0] tgt, input logic [31:0] w,
                            input bit keep_run);
        int cyc;
        cyc = 0;
        for (int k = 0; k <= ad; k++) begin
            chk("fetch_req", imem_req, 1);
            chk("fetch_addr", imem_addr, m_pc);
            chk("fetch_no_dec", dec_valid, 0);
            imem_ack     = (k == ad);
            imem_data    = (k == ad) ? w : $urandom;
            ex_done      = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            @(negedge clk); cyc++;
        end
        chk("dec_valid", dec_valid, 1);
        chk("dec_instr", instr, w);
        chk("dec_no_req", imem_req, 0);
        chk("dec_no_ex", ex_en, 0);
        imem_ack = 1'($urandom_range(0, 1));
        ex_done  = 1'($urandom_range(0, 1));
        @(negedge clk); cyc++;
        if (w[31:26] == HALT_OP) begin
            chk("halt_flag", halted, 1);
            chk("halt_pc", pc, m_pc);
            chk("halt_ret", retired, m_ret);
            chk("halt_no_ex", ex_en, 0);
            imem_ack = 1'b0;
            ex_done  = 1'b0;
            return;
        end
        for (int k = 0; k <= dd; k++) begin
            chk("ex_en", ex_en, 1);
            chk("ex_no_dec", dec_valid, 0);
            chk("ex_no_we", rf_we, 0);
            ex_done       = (k == dd);
            branch_taken  = (k == dd) ? br  : 1'($urandom_range(0, 1));
            branch_target = (k == dd) ? tgt : PC_W'($urandom);
            imem_ack      = 1'($urandom_range(0, 1));
            run           = keep_run;
            @(negedge clk); cyc++;
        end
        chk("wb_we", rf_we, 1);
        chk("wb_no_ex", ex_en, 0);
        chk("wb_pc_old", pc, m_pc);
        chk("wb_ret_old", retired, m_ret);
        m_pc = br ? tgt : m_pc + 1'b1;
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        ex_done  = 1'($urandom_range(0, 1));
        imem_ack = 1'($urandom_range(0, 1));
        @(negedge clk); cyc++;
        chk("latency", cyc, ad + dd + 4);
        chk("we_one_cycle", rf_we, 0);
        chk("pc_next", pc, m_pc);
        chk("retired", retired, m_ret);
        chk("not_halted", halted, 0);
        chk("req_after_wb", imem_req, keep_run);
        ex_done  = 1'b0;
        imem_ack = 1'b0;
    endtask

    initial begin
        int ad, dd, idle_n;
        bit br, kr;
        logic [PC_W-1:0] tgt;

        clkreset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = '0;
        ex_done = 1'b0; branch_taken = 1'b0; branch_target = '0;
        m_pc = '0; m_ret = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_dec", dec_valid, 0);
        chk("rst_ex", ex_en, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_halt", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ret", retired, 0);
        chk("rst_instr", instr, 0);
        clkreset = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        chk("idle_hold", imem_req, 0);
        imem_ack = 1'b0;
        run = 1'b1;
        @(negedge clk);

        // Back-to-back zero-latency instructions
        repeat (3) do_instr(0, 0, 1'b0, '0, rand_word(), 1'b1);
        chk("three_ret", retired, 3);
        // Slow fetch
        do_instr(3, 0, 1'b0, '0, rand_word(), 1'b1);
        // Wrap, branch, branch-to-self
        do_instr(0, 0, 1'b1, 6'h3F, rand_word(), 1'b1);
        do_instr(0, 1, 1'b0, '0, rand_word(), 1'b1);
        chk("wrap_zero", pc, 0);
        do_instr(0, 0, 1'b1, 6'h05, rand_word(), 1'b1);
        chk("branch_5", pc, 5);
        do_instr(1, 0, 1'b1, m_pc, rand_word(), 1'b1);
        chk("self_branch", pc, 5);
        // Run dropped during EXECUTE
        do_instr(0, 2, 1'b0, '0, rand_word(), 1'b0);
        run = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ad  = $urandom_range(0, 3);
            dd  = $urandom_range(0, 3);
            br  = ($urandom_range(0, 3) == 0);
            tgt = PC_W'($urandom);
            kr  = ($urandom_range(0, 4) != 0);
            do_instr(ad, dd, br, tgt, rand_word(), kr);
            if (!kr) begin
                idle_n = $urandom_range(0, 3);
                for (int j = 0; j < idle_n; j++) begin
                    imem_ack = 1'($urandom_range(0, 1));
                    ex_done  = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    chk("idle_req", imem_req, 0);
                    chk("idle_pc", pc, m_pc);
                end
                imem_ack = 1'b0;
                ex_done  = 1'b0;
                run = 1'b1;
                @(negedge clk);
            end
        end

        // Reset in the middle of EXECUTE with ex_done pending
        imem_ack = 1'b1; imem_data = rand_word();
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("pre_rst_ex", ex_en, 1);
        clkreset = 1'b1; ex_done = 1'b1; branch_taken = 1'b1; branch_target = 6'h07;
        run = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_ex", ex_en, 0);
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_ret", retired, 0);
        chk("mid_rst_instr", instr, 0);
        clkreset = 1'b0;
        @(negedge clk);
        chk("post_rst_we", rf_we, 0);
        chk("post_rst_req", imem_req, 0);
        ex_done = 1'b0;
        m_pc = '0; m_ret = '0;
        run = 1'b1;
        @(negedge clk);

        // One normal instruction, then HALT
        do_instr(0, 0, 1'b0, '0, rand_word(), 1'b1);
        do_instr(0, 0, 1'b0, '0, 32'hFC000000, 1'b1);
        for (int j = 0; j < 6; j++) begin
            run      = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1));
            ex_done  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_stay", halted, 1);
            chk("halt_req", imem_req, 0);
            chk("halt_strobes", {dec_valid, ex_en, rf_we}, 0);
            chk("halt_pc_frz", pc, m_pc);
            chk("halt_ret_frz", retired, m_ret);
        end
        clkreset = 1'b1; run = 1'b0; imem_ack = 1'b0; ex_done = 1'b0;
        @(negedge clk);
        chk("halt_rst_flag", halted, 0);
        chk("halt_rst_pc", pc, 0);
        chk("halt_rst_ret", retired, 0);
        clkreset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
